// File: rtl/ifetch_decode.sv
// RV32I fetch over a start/done memory port plus field/immediate decode, paced by a free-running
// 4-phase counter. Define FETCH_CTRL_STALL_EN to hold fetch after JAL/JALR/BRANCH until resolved.
module ifetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [1:0]  counter,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [2:0]  fun3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [6:0]  fun7,
  output logic [31:0] imm,
  output logic [31:0] opc,
  input  logic [31:0] npc,
  input  logic        get_npc,
  input  logic        is_busy,
  output logic        im_start,
  output logic [31:0] im_adr,
  input  logic [31:0] im_out,
  input  logic        im_busy,
  input  logic        im_done
);

  localparam logic [31:0] Nop      = 32'h0000_0013;
  localparam logic [6:0]  OpLoad   = 7'b0000011;
  localparam logic [6:0]  OpImm    = 7'b0010011;
  localparam logic [6:0]  OpJalr   = 7'b1100111;
  localparam logic [6:0]  OpStore  = 7'b0100011;
  localparam logic [6:0]  OpBranch = 7'b1100011;
  localparam logic [6:0]  OpLui    = 7'b0110111;
  localparam logic [6:0]  OpAuipc  = 7'b0010111;
  localparam logic [6:0]  OpJal    = 7'b1101111;
  localparam logic [6:0]  OpReg    = 7'b0110011;

  typedef enum logic [1:0] {
    StFetch,
    StReady,
`ifdef FETCH_CTRL_STALL_EN
    StIssued,
    StWaitCf
`else
    StIssued
`endif
  } state_e;

  function automatic logic known_op(input logic [6:0] op);
    case (op)
      OpLoad, OpImm, OpJalr, OpStore, OpBranch,
      OpLui, OpAuipc, OpJal, OpReg: known_op = 1'b1;
      default:                      known_op = 1'b0;
    endcase
  endfunction

`ifdef FETCH_CTRL_STALL_EN
  function automatic logic is_ctrl(input logic [6:0] op);
    is_ctrl = (op == OpJal) || (op == OpJalr) || (op == OpBranch);
  endfunction
`endif

  logic [1:0]  counter_q, counter_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] iss_q, iss_d;
  logic [31:0] iss_pc_q, iss_pc_d;
  logic        iss_valid_q, iss_valid_d;
  logic        im_start_q, im_start_d;
  state_e      state_q, state_d;
  logic        fetch_done;

  // Downstream status the default build never needs to look at.
  logic unused_inputs;
  assign unused_inputs = ^{is_busy, get_npc};

  always_comb begin
    counter_d   = counter_q + 2'd1;
    pc_d        = pc_q;
    ir_d        = ir_q;
    iss_d       = iss_q;
    iss_pc_d    = iss_pc_q;
    iss_valid_d = iss_valid_q;
    state_d     = state_q;

    fetch_done = (state_q == StFetch) && im_start_q && im_done && !im_busy;
    if (fetch_done) begin
      ir_d    = im_out;
      state_d = StReady;
    end

    // Issue edge: a word latched on this same edge waits for the next slot.
    if (counter_q == 2'd3) begin
      if (state_q == StReady) begin
        iss_d       = known_op(ir_q[6:0]) ? ir_q : Nop;
        iss_pc_d    = pc_q;
        iss_valid_d = 1'b1;
        state_d     = StIssued;
      end else begin
        iss_d       = Nop;
        iss_valid_d = 1'b0;
      end
    end

    if (counter_q == 2'd0) begin
      if (iss_valid_q) begin
        pc_d        = npc;
        iss_valid_d = 1'b0;
        state_d     = StFetch;
`ifdef FETCH_CTRL_STALL_EN
        if (is_ctrl(iss_q[6:0])) state_d = StWaitCf;
`endif
      end
`ifdef FETCH_CTRL_STALL_EN
      else if ((state_q == StWaitCf) && get_npc) begin
        pc_d    = npc;
        state_d = StFetch;
      end
`endif
    end

    im_start_d = (state_d == StFetch);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter_q   <= 2'd0;
      pc_q        <= RESET_PC;
      ir_q        <= 32'h0;
      iss_q       <= Nop;
      iss_pc_q    <= 32'h0;
      iss_valid_q <= 1'b0;
      im_start_q  <= 1'b0;
      state_q     <= StFetch;
    end else begin
      counter_q   <= counter_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      iss_q       <= iss_d;
      iss_pc_q    <= iss_pc_d;
      iss_valid_q <= iss_valid_d;
      im_start_q  <= im_start_d;
      state_q     <= state_d;
    end
  end

  always_comb begin
    case (iss_q[6:0])
      OpLoad, OpImm, OpJalr: imm = {{20{iss_q[31]}}, iss_q[31:20]};
      OpStore:  imm = {{20{iss_q[31]}}, iss_q[31:25], iss_q[11:7]};
      OpBranch: imm = {{20{iss_q[31]}}, iss_q[7], iss_q[30:25], iss_q[11:8], 1'b0};
      OpLui, OpAuipc: imm = {iss_q[31:12], 12'b0};
      OpJal:    imm = {{12{iss_q[31]}}, iss_q[19:12], iss_q[20], iss_q[30:21], 1'b0};
      default:  imm = 32'h0;
    endcase
  end

  assign counter  = counter_q;
  assign opcode   = iss_q[6:0];
  assign rd       = iss_q[11:7];
  assign fun3     = iss_q[14:12];
  assign rs1      = iss_q[19:15];
  assign rs2      = iss_q[24:20];
  assign fun7     = iss_q[31:25];
  assign opc      = iss_pc_q;
  assign im_start = im_start_q;
  assign im_adr   = pc_q;

endmodule
